// File: rtl/soc_gpio_pkg.sv
// soc_gpio_pkg: register map, interrupt encodings and default pin count shared by
// the GPIO interrupt controller and its testbench.
package soc_gpio_pkg;
    localparam int GPIO_NUM_PINS_DEF = 32;
    localparam logic [11:0] GPIO_OFF_IN       = 12'h000;
    localparam logic [11:0] GPIO_OFF_INT_EN   = 12'h004;
    localparam logic [11:0] GPIO_OFF_INT_TYPE = 12'h008;
    localparam logic [11:0] GPIO_OFF_INT_POL  = 12'h00C;
    localparam logic [11:0] GPIO_OFF_INT_BOTH = 12'h010;
    localparam logic [11:0] GPIO_OFF_INT_STAT = 12'h014;
    localparam logic [11:0] GPIO_OFF_INT_CLR  = 12'h018;
    localparam logic [11:0] GPIO_OFF_DEB_CNT  = 12'h01C;
    typedef enum logic { INT_LEVEL = 1'b0, INT_EDGE = 1'b1 } gpio_int_type_e;
    typedef enum logic { POL_LOW = 1'b0, POL_HIGH = 1'b1 } gpio_int_pol_e;
endpackage

// File: rtl/soc_gpio_irq_ctrl_if.sv
// soc_gpio_irq_ctrl_if: zero-wait APB bus used to configure and service the GPIO block.
interface soc_gpio_irq_ctrl_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/soc_gpio_irq_ctrl_in_filter.sv
// gpio_in_filter: per-pin 2-flop synchronizer and level register; with GPIO_DEBOUNCE_EN
// the level only follows after DEB_CNT+1 consecutive mismatching samples.
module gpio_in_filter #(
    parameter int DEB_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin_i,
    input  logic [DEB_W-1:0] deb_cnt,
    output logic             lvl_o
);
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else sync <= {sync[0], pin_i};
    end
`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt;
    // Threshold is read live, so a new DEB_CNT applies to the count already running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            lvl_o <= 1'b0;
        end else if (sync[1] == lvl_o) begin
            cnt <= '0;
        end else if (cnt >= deb_cnt) begin
            cnt   <= '0;
            lvl_o <= sync[1];
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_deb;
    assign unused_deb = ^deb_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_o <= 1'b0;
        else lvl_o <= sync[1];
    end
`endif
endmodule

// File: rtl/soc_gpio_irq_ctrl.sv
// soc_gpio_irq_ctrl: filtered GPIO inputs, per-pin edge/level interrupts and APB registers.
// Define GPIO_DEBOUNCE_EN to add per-pin debounce and the DEB_CNT register at 0x1C.
module soc_gpio_irq_ctrl
    import soc_gpio_pkg::*;
#(
    parameter int NUM_PINS = GPIO_NUM_PINS_DEF,
    parameter int DEB_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    soc_gpio_irq_ctrl_if.slave  apb,
    input  logic [NUM_PINS-1:0] pin_i,
    output logic [NUM_PINS-1:0] gpio_in_o,
    output logic [NUM_PINS-1:0] irq_vec_o,
    output logic                irq_o
);
    logic [NUM_PINS-1:0] lvl, lvl_d, int_en, int_type, int_pol, int_both, sticky, status;
    logic [NUM_PINS-1:0] rise, fall, set, clr, type_chg, wdata;
    logic [DEB_W-1:0]    deb_cnt;
    logic [11:0]         off;
    logic [31:0]         rdata;
    logic                wr, mapped, unused_apb;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_in_filter #(.DEB_W(DEB_W)) u_filt (
            .clk(clk), .rst_n(rst_n), .pin_i(pin_i[i]), .deb_cnt(deb_cnt), .lvl_o(lvl[i])
        );
    end

    assign off        = {apb.paddr[11:2], 2'b00};
    assign unused_apb = ^{apb.paddr[31:12], apb.paddr[1:0], apb.pwdata};
    assign wr         = apb.psel & apb.penable & apb.pwrite;
    assign wdata      = apb.pwdata[NUM_PINS-1:0];

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (off)
            GPIO_OFF_IN:       rdata = 32'(lvl);
            GPIO_OFF_INT_EN:   rdata = 32'(int_en);
            GPIO_OFF_INT_TYPE: rdata = 32'(int_type);
            GPIO_OFF_INT_POL:  rdata = 32'(int_pol);
            GPIO_OFF_INT_BOTH: rdata = 32'(int_both);
            GPIO_OFF_INT_STAT: rdata = 32'(status);
            GPIO_OFF_INT_CLR:  rdata = '0;
`ifdef GPIO_DEBOUNCE_EN
            GPIO_OFF_DEB_CNT:  rdata = 32'(deb_cnt);
`endif
            default:           mapped = 1'b0;
        endcase
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = apb.psel & apb.penable & ~mapped;

    // BOTH overrides POL for edge pins; set wins over a same-cycle W1C.
    assign rise      = lvl & ~lvl_d;
    assign fall      = ~lvl & lvl_d;
    assign set       = int_en & int_type & ((rise & (int_pol | int_both)) | (fall & (~int_pol | int_both)));
    assign clr       = (wr && off == GPIO_OFF_INT_CLR) ? wdata : '0;
    assign type_chg  = (wr && off == GPIO_OFF_INT_TYPE) ? (wdata ^ int_type) : '0;
    assign status    = sticky | (~int_type & int_en & ~(lvl ^ int_pol));
    assign irq_vec_o = status & int_en;
    assign gpio_in_o = lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_en   <= '0;
            int_type <= '0;
            int_pol  <= '0;
            int_both <= '0;
            sticky   <= '0;
            lvl_d    <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr && off == GPIO_OFF_INT_EN)   int_en   <= wdata;
            if (wr && off == GPIO_OFF_INT_TYPE) int_type <= wdata;
            if (wr && off == GPIO_OFF_INT_POL)  int_pol  <= wdata;
            if (wr && off == GPIO_OFF_INT_BOTH) int_both <= wdata;
            sticky <= (set | (sticky & ~clr)) & ~type_chg;
            lvl_d  <= lvl;
            irq_o  <= |irq_vec_o;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) deb_cnt <= '0;
        else if (wr && off == GPIO_OFF_DEB_CNT) deb_cnt <= apb.pwdata[DEB_W-1:0];
    end
`else
    assign deb_cnt = '0;
`endif
endmodule
